// File: rtl/flag_ctrl_pkg.sv
// Shared CPU constants: opcodes, condition codes, flag bit positions, halt FSM states.
package flag_ctrl_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned CC_W   = 3;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD    = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB    = 4'b0001;
  localparam logic [OP_W-1:0] OP_XOR    = 4'b0010;
  localparam logic [OP_W-1:0] OP_RED    = 4'b0011;
  localparam logic [OP_W-1:0] OP_SLL    = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRA    = 4'b0101;
  localparam logic [OP_W-1:0] OP_ROR    = 4'b0110;
  localparam logic [OP_W-1:0] OP_PADDSB = 4'b0111;
  localparam logic [OP_W-1:0] OP_LW     = 4'b1000;
  localparam logic [OP_W-1:0] OP_SW     = 4'b1001;
  localparam logic [OP_W-1:0] OP_LLB    = 4'b1010;
  localparam logic [OP_W-1:0] OP_LHB    = 4'b1011;
  localparam logic [OP_W-1:0] OP_B      = 4'b1100;
  localparam logic [OP_W-1:0] OP_BR     = 4'b1101;
  localparam logic [OP_W-1:0] OP_PCS    = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT    = 4'b1111;

  localparam logic [CC_W-1:0] CC_NE = 3'b000;
  localparam logic [CC_W-1:0] CC_EQ = 3'b001;
  localparam logic [CC_W-1:0] CC_GT = 3'b010;
  localparam logic [CC_W-1:0] CC_LT = 3'b011;
  localparam logic [CC_W-1:0] CC_GE = 3'b100;
  localparam logic [CC_W-1:0] CC_LE = 3'b101;
  localparam logic [CC_W-1:0] CC_OV = 3'b110;
  localparam logic [CC_W-1:0] CC_UN = 3'b111;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Which flag bits an opcode is allowed to write.
  function automatic flags_t update_mask(input logic [OP_W-1:0] op);
    flags_t m;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b001;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_ctrl_if.sv
// Pipeline-side signals of the flag controller: EX/decode inputs and flag/halt outputs.
interface flag_ctrl_if;
  import flag_ctrl_pkg::*;

  logic              Stall;
  logic              Flush;
  logic              ExValid;
  logic [OP_W-1:0]   ExOpcode;
  flags_t            AluFlag;
  logic              DecValid;
  logic [OP_W-1:0]   DecOpcode;
  logic [CC_W-1:0]   Cond;
  flags_t            Flags;
  logic              BranchTaken;
  logic              HaltPending;
  logic              Halt;

  modport master (
    output Stall, Flush, ExValid, ExOpcode, AluFlag, DecValid, DecOpcode, Cond,
    input  Flags, BranchTaken, HaltPending, Halt
  );

  modport slave (
    input  Stall, Flush, ExValid, ExOpcode, AluFlag, DecValid, DecOpcode, Cond,
    output Flags, BranchTaken, HaltPending, Halt
  );
endinterface

// File: rtl/flag_ctrl_branch_cond.sv
// Combinational branch condition evaluator over {N,V,Z}.
module flag_ctrl_branch_cond
  import flag_ctrl_pkg::*;
(
  input  flags_t          flags,
  input  logic [CC_W-1:0] cond,
  output logic            taken_c
);

  logic n, v, z;

  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign z = flags[FLAG_Z];

  // Decode condition code against the supplied flags.
  always_comb begin
    taken_c = 1'b0;
    case (cond)
      CC_NE:   taken_c = ~z;
      CC_EQ:   taken_c = z;
      CC_GT:   taken_c = ~z & ~n;
      CC_LT:   taken_c = n;
      CC_GE:   taken_c = z | (~z & ~n);
      CC_LE:   taken_c = n | z;
      CC_OV:   taken_c = v;
      default: taken_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_ctrl.sv
// Architectural N/V/Z register, EX->decode flag forwarding, branch resolve and HLT drain sequencing.
module flag_ctrl
  import flag_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic        clk,
  input logic        rst_n,
  flag_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  flags_t            flags_q;
  flags_t            mask_c;
  flags_t            next_flags_c;
  flags_t            eff_flags_c;
  logic              upd_c;
  logic              wr_c;
  logic              halted_c;
  logic              pending_c;
  logic              is_branch_c;
  logic              cond_taken_c;
  logic              hlt_accept_c;

  // Flag merge; masked-out bits come only from the register so ALU X cannot leak.
  always_comb begin
    mask_c       = update_mask(bus.ExOpcode);
    next_flags_c = (bus.AluFlag & mask_c) | (flags_q & ~mask_c);
    upd_c        = bus.ExValid & ~bus.Flush & ~halted_c & (|mask_c);
    wr_c         = upd_c & ~bus.Stall;
    eff_flags_c  = upd_c ? next_flags_c : flags_q;
  end

  // Architectural flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (wr_c) begin
      flags_q <= next_flags_c;
    end
  end

  flag_ctrl_branch_cond u_branch_cond (
    .flags   (eff_flags_c),
    .cond    (bus.Cond),
    .taken_c (cond_taken_c)
  );

  // Branch resolves in decode against forwarded flags.
  always_comb begin
    is_branch_c     = (bus.DecOpcode == OP_B) || (bus.DecOpcode == OP_BR);
    bus.BranchTaken = bus.DecValid & ~bus.Flush & ~halted_c & is_branch_c & cond_taken_c;
  end

  // Halt FSM state and drain counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Halt FSM next state; drain counter freezes on stall.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hlt_accept_c = bus.DecValid & (bus.DecOpcode == OP_HLT) & ~bus.Flush & ~bus.Stall;
    case (state_q)
      ST_RUN: begin
        if (hlt_accept_c) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (!bus.Stall) begin
          if (cnt_q == '0) begin
            state_d = ST_HALTED;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Halt FSM outputs decoded from the state register.
  always_comb begin
    pending_c = 1'b0;
    halted_c  = 1'b0;
    case (state_q)
      ST_DRAIN:  pending_c = 1'b1;
      ST_HALTED: halted_c  = 1'b1;
      default: begin
        pending_c = 1'b0;
        halted_c  = 1'b0;
      end
    endcase
  end

  assign bus.Flags       = flags_q;
  assign bus.HaltPending = pending_c;
  assign bus.Halt        = halted_c;

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed bench for flag_ctrl with a queued-expectation scoreboard.
module tb_flag_ctrl;
  import flag_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    string      name;
    int         cyc;
    logic [2:0] f;
    logic       bt;
    logic       hp;
    logic       h;
  } exp_t;

  exp_t sb[$];

  flag_ctrl_if bus ();

  flag_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are sampled mid-cycle and compared with queued expectations.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || bus.Flags !== e.f || bus.BranchTaken !== e.bt ||
          bus.HaltPending !== e.hp || bus.Halt !== e.h) begin
        failures++;
        $display("FAIL %s: got Flags=%b BranchTaken=%b HaltPending=%b Halt=%b, want Flags=%b BranchTaken=%b HaltPending=%b Halt=%b",
                 e.name, bus.Flags, bus.BranchTaken, bus.HaltPending, bus.Halt,
                 e.f, e.bt, e.hp, e.h);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [3:0] eop, input logic [2:0] alu,
                       input logic dv, input logic [3:0] dop, input logic [2:0] cc,
                       input logic st, input logic fl);
    bus.ExValid   = ev;
    bus.ExOpcode  = eop;
    bus.AluFlag   = alu;
    bus.DecValid  = dv;
    bus.DecOpcode = dop;
    bus.Cond      = cc;
    bus.Stall     = st;
    bus.Flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic exp_push(input string nm, input logic [2:0] f, input logic bt,
                          input logic hp, input logic h);
    exp_t e;
    e.name = nm;
    e.cyc  = cyc;
    e.f    = f;
    e.bt   = bt;
    e.hp   = hp;
    e.h    = h;
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    nxt(); nxt();
    exp_push("reset", 3'b000, 0, 0, 0);

    // Full-mask updates
    rst_n = 1'b1;
    drive(1, OP_ADD, 3'b010, 0, 4'h0, 3'b000, 0, 0);  exp_push("add_pre", 3'b000, 0, 0, 0);
    nxt(); drive(1, OP_SUB, 3'b100, 0, 4'h0, 3'b000, 0, 0);  exp_push("add", 3'b010, 0, 0, 0);
    nxt(); drive(1, OP_ADD, 3'b110, 0, 4'h0, 3'b000, 0, 0);  exp_push("sub", 3'b100, 0, 0, 0);

    // Partial mask and no-update opcodes
    nxt(); drive(1, OP_XOR, 3'b101, 0, 4'h0, 3'b000, 0, 0);  exp_push("set110", 3'b110, 0, 0, 0);
    nxt(); drive(1, OP_LW, 3'b000, 0, 4'h0, 3'b000, 0, 0);   exp_push("xor_z", 3'b111, 0, 0, 0);
    nxt(); drive(1, OP_SLL, 3'b000, 1, OP_B, CC_OV, 0, 0);   exp_push("lw_fwd_merged", 3'b111, 1, 0, 0);
    nxt(); drive(1, OP_ADD, 3'b000, 0, 4'h0, 3'b000, 0, 0);  exp_push("sll_z", 3'b110, 0, 0, 0);

    // Forwarding into decode
    nxt(); drive(1, OP_SUB, 3'b100, 1, OP_B, CC_LT, 0, 0);   exp_push("fwd_lt", 3'b000, 1, 0, 0);
    nxt(); drive(1, OP_ADD, 3'b000, 1, OP_BR, CC_GT, 0, 0);  exp_push("fwd_gt_taken", 3'b100, 1, 0, 0);
    nxt(); drive(1, OP_SUB, 3'b100, 1, OP_B, CC_GT, 0, 0);   exp_push("fwd_gt_not", 3'b000, 0, 0, 0);
    nxt(); drive(0, 4'h0, 3'b000, 1, OP_ADD, CC_UN, 0, 0);   exp_push("non_branch", 3'b100, 0, 0, 0);

    // Stall holds the update but forwarding still sees it
    nxt(); drive(1, OP_ADD, 3'b001, 1, OP_B, CC_EQ, 1, 0);   exp_push("stall_fwd", 3'b100, 1, 0, 0);
    nxt(); drive(1, OP_ADD, 3'b001, 1, OP_B, CC_EQ, 1, 0);   exp_push("stall_hold", 3'b100, 1, 0, 0);
    nxt(); drive(1, OP_ADD, 3'b001, 0, 4'h0, 3'b000, 0, 0);  exp_push("stall_release", 3'b100, 0, 0, 0);

    // Flush kills EX update and decode branch/HLT
    nxt(); drive(1, OP_ADD, 3'b110, 1, OP_B, CC_EQ, 0, 1);   exp_push("stall_update", 3'b001, 0, 0, 0);
    nxt(); drive(1, OP_ADD, 3'b110, 1, OP_HLT, 3'b000, 1, 1); exp_push("flush_branch", 3'b001, 0, 0, 0);
    nxt(); drive(0, 4'h0, 3'b000, 1, OP_HLT, 3'b000, 0, 1);  exp_push("flush_stall", 3'b001, 0, 0, 0);
    nxt(); drive(0, 4'h0, 3'b000, 1, OP_HLT, 3'b000, 1, 0);  exp_push("hlt_flushed", 3'b001, 0, 0, 0);

    // HLT drain with one stall cycle
    nxt(); drive(0, 4'h0, 3'b000, 1, OP_HLT, 3'b000, 0, 0);  exp_push("hlt_stalled", 3'b001, 0, 0, 0);
    nxt(); drive(1, OP_ADD, 3'b100, 1, OP_HLT, 3'b000, 0, 0); exp_push("drain1", 3'b001, 0, 1, 0);
    nxt(); drive(0, 4'h0, 3'b000, 0, 4'h0, 3'b000, 1, 0);    exp_push("drain2_stall", 3'b100, 0, 1, 0);
    nxt(); drive(0, 4'h0, 3'b000, 1, OP_B, CC_UN, 0, 1);     exp_push("drain3_flush", 3'b100, 0, 1, 0);
    nxt(); idle();                                             exp_push("drain4", 3'b100, 0, 1, 0);
    nxt(); drive(1, OP_ADD, 3'b011, 1, OP_B, CC_UN, 0, 0);   exp_push("halted", 3'b100, 0, 0, 1);
    nxt(); drive(0, 4'h0, 3'b000, 1, OP_HLT, 3'b000, 0, 0);  exp_push("halt_noupd", 3'b100, 0, 0, 1);
    nxt(); rst_n = 1'b0; idle();                              exp_push("halt_sticky", 3'b100, 0, 0, 1);

    // Reset out of HALTED, then reset mid-drain, then a full drain
    nxt(); rst_n = 1'b1; drive(0, 4'h0, 3'b000, 1, OP_HLT, 3'b000, 0, 0); exp_push("rst_halted", 3'b000, 0, 0, 0);
    nxt(); drive(1, OP_ADD, 3'b111, 0, 4'h0, 3'b000, 0, 0);  exp_push("rd1", 3'b000, 0, 1, 0);
    nxt(); rst_n = 1'b0; idle();                              exp_push("rd2", 3'b111, 0, 1, 0);
    nxt(); rst_n = 1'b1; drive(0, 4'h0, 3'b000, 1, OP_HLT, 3'b000, 0, 0); exp_push("rst_drain", 3'b000, 0, 0, 0);
    nxt(); idle();                                             exp_push("re1", 3'b000, 0, 1, 0);
    nxt();                                                     exp_push("re2", 3'b000, 0, 1, 0);
    nxt();                                                     exp_push("re3", 3'b000, 0, 1, 0);
    nxt();                                                     exp_push("re_halted", 3'b000, 0, 0, 1);
    nxt(); nxt();

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
